// File: rtl/matrix_alu_seq_pkg.sv
// rtl/matrix_alu_seq_pkg.sv - shared sizes, opcodes, matrix types and FSM states for matrix_alu_seq
// Purpose: single place for matrix geometry, element width and the opcode map.
// Ports: none (package).
package matrix_alu_seq_pkg;

  // Matrix dimension is 2**WIDTH_BIT (rows = cols).
  localparam int WIDTH_BIT = 2;
  localparam int WIDTH     = 1 << WIDTH_BIT;
  localparam int DATA_W    = 32;
  // matmul accumulator: full product width plus headroom for WIDTH terms.
  localparam int ACC_W     = 2 * DATA_W + WIDTH_BIT;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_MUL     = 3'd2;
  localparam logic [2:0] OP_DIV     = 3'd3;
  localparam logic [2:0] OP_MOD     = 3'd4;
  localparam logic [2:0] OP_MATMUL  = 3'd5;
  localparam logic [2:0] OP_TRANS   = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [0:WIDTH-1]        row_t;
  typedef row_t  [0:WIDTH-1]        matrix_t;

  localparam elem_t ELEM_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam elem_t ELEM_NEG_ONE = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_alu_seq_row_unit.sv
// rtl/matrix_alu_seq_row_unit.sv - combinational engine producing one result row of the matrix ALU
// Purpose: computes result row r from row r of a, row r of b, column r of a and all of b.
// Ports:
//   a_row    in   row r of a
//   a_col    in   column r of a (transpose source)
//   b_row    in   row r of b
//   b_full   in   whole b matrix (matmul)
//   sel      in   opcode
//   res_row  out  result row r
//   div_zero out  some divisor in this row was zero (div/mod only)
module matrix_alu_seq_row_unit
  import matrix_alu_seq_pkg::*;
(
  input  row_t       a_row,
  input  row_t       a_col,
  input  row_t       b_row,
  input  matrix_t    b_full,
  input  logic [2:0] sel,
  output row_t       res_row,
  output logic       div_zero
);

  elem_t                      x;
  elem_t                      y;
  logic signed [2*DATA_W-1:0] ax;
  logic signed [2*DATA_W-1:0] bx;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;

  always_comb begin
    res_row  = '0;
    div_zero = 1'b0;
    x        = '0;
    y        = '0;
    ax       = '0;
    bx       = '0;
    prod     = '0;
    acc      = '0;
    for (int c = 0; c < WIDTH; c++) begin
      x = a_row[c];
      y = b_row[c];
      case (sel)
        OP_ADD: res_row[c] = x + y;
        OP_SUB: res_row[c] = x - y;
        OP_MUL: res_row[c] = x * y;
        OP_DIV: begin
          if (y == '0) begin
            res_row[c] = '0;
            div_zero   = 1'b1;
          end else if (x == ELEM_MIN && y == ELEM_NEG_ONE) begin
            // The only overflowing quotient; wraps back to MIN.
            res_row[c] = ELEM_MIN;
          end else begin
            res_row[c] = x / y;
          end
        end
        OP_MOD: begin
          if (y == '0) begin
            res_row[c] = '0;
            div_zero   = 1'b1;
          end else if (x == ELEM_MIN && y == ELEM_NEG_ONE) begin
            res_row[c] = '0;
          end else begin
            res_row[c] = x % y;
          end
        end
        OP_MATMUL: begin
          acc = '0;
          for (int k = 0; k < WIDTH; k++) begin
            ax   = a_row[k];
            bx   = b_full[k][c];
            prod = ax * bx;
            acc  = acc + {{WIDTH_BIT{prod[2*DATA_W-1]}}, prod};
          end
          res_row[c] = acc[DATA_W-1:0];
        end
        OP_TRANS: res_row[c] = a_col[c];
        default:  res_row[c] = '0;
      endcase
    end
  end

endmodule

// File: rtl/matrix_alu_seq.sv
// rtl/matrix_alu_seq.sv - handshaked multi-cycle matrix ALU, one result row per cycle
// Purpose: captures a, b, sel on accept, builds the result one row per cycle, then
//          holds result and flags until the consumer takes them.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (ready only when idle)
//   sel, a, b             opcode and operand matrices
//   out_valid / out_ready result handshake
//   result                result matrix
//   div_zero, illegal_op  op flags, meaningful with out_valid
module matrix_alu_seq
  import matrix_alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] sel,
  input  matrix_t    a,
  input  matrix_t    b,
  output logic       out_valid,
  input  logic       out_ready,
  output matrix_t    result,
  output logic       div_zero,
  output logic       illegal_op
);

  state_t               state_q;
  state_t               state_d;
  logic [WIDTH_BIT-1:0] row_q;
  logic [2:0]           sel_q;
  matrix_t              a_q;
  matrix_t              b_q;
  matrix_t              result_q;
  logic                 div_zero_q;
  logic                 illegal_q;

  row_t                 a_col;
  row_t                 row_res;
  logic                 row_div_zero;
  logic                 accept;
  logic                 last_row;

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign last_row   = (row_q == WIDTH_BIT'(WIDTH - 1));
  assign result     = result_q;
  assign div_zero   = div_zero_q;
  assign illegal_op = illegal_q;

  always_comb begin
    a_col = '0;
    for (int r = 0; r < WIDTH; r++) begin
      a_col[r] = a_q[r][row_q];
    end
  end

  matrix_alu_seq_row_unit u_row (
    .a_row    (a_q[row_q]),
    .a_col    (a_col),
    .b_row    (b_q[row_q]),
    .b_full   (b_q),
    .sel      (sel_q),
    .res_row  (row_res),
    .div_zero (row_div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last_row)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Result register is only ever written row by row; rows from a previous op
  // are overwritten before out_valid rises, so no per-op clear is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      sel_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q        <= a;
        b_q        <= b;
        sel_q      <= sel;
        row_q      <= '0;
        div_zero_q <= 1'b0;
        illegal_q  <= (sel == OP_ILLEGAL);
      end else if (state_q == ST_RUN) begin
        result_q[row_q] <= row_res;
        div_zero_q      <= div_zero_q | row_div_zero;
        row_q           <= row_q + WIDTH_BIT'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// tb/tb_matrix_alu_seq.sv - self-checking bench for matrix_alu_seq
module tb_matrix_alu_seq;
  import matrix_alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] sel = 3'd0;
  matrix_t    a = '0;
  matrix_t    b = '0;
  logic       in_ready;
  logic       out_valid;
  logic       div_zero;
  logic       illegal_op;
  matrix_t    result;

  int      checks = 0;
  int      errors = 0;
  matrix_t exp_res = '0;
  bit      exp_dz = 1'b0;
  bit      exp_ill = 1'b0;
  bit      exp_valid = 1'b0;

  always #5 clk = ~clk;

  matrix_alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sel        (sel),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .div_zero   (div_zero),
    .illegal_op (illegal_op)
  );

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0b required %0b", name, act, req);
    end
  endtask

  task automatic chk_mat(input string name, input matrix_t act, input matrix_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  function automatic matrix_t fill(input int v);
    matrix_t m;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        m[i][j] = v;
    return m;
  endfunction

  // Reference: whole-matrix result from plain integer arithmetic.
  function automatic void model(input matrix_t ma, input matrix_t mb, input int op,
                                output matrix_t r, output bit dz, output bit ill);
    int     x, y, p, q;
    longint s;
    r   = '0;
    dz  = 1'b0;
    ill = (op == 7);
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        x = ma[i][j];
        y = mb[i][j];
        s = 0;
        case (op)
          0: s = longint'(x) + longint'(y);
          1: s = longint'(x) - longint'(y);
          2: s = longint'(x) * longint'(y);
          3: if (y == 0) dz = 1'b1; else s = longint'(x) / longint'(y);
          4: if (y == 0) dz = 1'b1;
             else s = longint'(x) - (longint'(x) / longint'(y)) * longint'(y);
          5: for (int k = 0; k < WIDTH; k++) begin
               p = ma[i][k];
               q = mb[k][j];
               s = s + longint'(p) * longint'(q);
             end
          6: s = longint'(int'(ma[j][i]));
          default: s = 0;
        endcase
        r[i][j] = s[31:0];
      end
    end
  endfunction

  // Whenever a result is presented it must match the model and stay put.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk_bit("cmp_out_valid_expected", exp_valid, 1'b1);
      chk_mat("cmp_result", result, exp_res);
      chk_bit("cmp_div_zero", div_zero, exp_dz);
      chk_bit("cmp_illegal_op", illegal_op, exp_ill);
      chk_bit("cmp_in_ready_busy", in_ready, 1'b0);
    end
  end

  task automatic run_op(input logic [2:0] op, input matrix_t ma, input matrix_t mb,
                        input int hold, input bit poke,
                        output matrix_t got, output bit gdz, output bit gill);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_bit("accept_in_ready", in_ready, 1'b1);
    sel = op;
    a = ma;
    b = mb;
    in_valid = 1'b1;
    model(ma, mb, int'(op), exp_res, exp_dz, exp_ill);
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ma;
    b = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      chk_bit($sformatf("latency_cycle_%0d", i + 1), out_valid, (i == WIDTH));
    end
    got  = result;
    gdz  = div_zero;
    gill = illegal_op;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (poke) begin
        in_valid = 1'b1;
        sel = 3'd0;
        a = fill(h + 100);
        b = fill(h);
      end
      @(posedge clk);
      #1;
      chk_bit("hold_out_valid", out_valid, 1'b1);
      chk_bit("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    exp_valid = 1'b0;
    chk_bit("consume_out_valid", out_valid, 1'b0);
    chk_bit("consume_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk_bit("idle_in_ready", in_ready, 1'b1);
  endtask

  matrix_t got, ident, seq, tr, m1, m2;
  bit      gdz, gill;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_mat("reset_result", result, '0);
    chk_bit("reset_div_zero", div_zero, 1'b0);
    chk_bit("reset_illegal_op", illegal_op, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    ident = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ident[i][i] = 1;
      for (int j = 0; j < WIDTH; j++) begin
        seq[i][j] = i * WIDTH + j + 1;
        tr[i][j]  = j * WIDTH + i + 1;
      end
    end

    run_op(3'd0, fill(7), fill(-3), 0, 1'b0, got, gdz, gill);
    chk_mat("lit_add", got, fill(4));

    run_op(3'd5, ident, seq, 2, 1'b0, got, gdz, gill);
    chk_mat("lit_matmul_identity", got, seq);

    run_op(3'd6, seq, fill(0), 0, 1'b0, got, gdz, gill);
    chk_mat("lit_transpose", got, tr);

    m1 = fill(2);
    m1[1][2] = 0;
    m2 = fill(-3);
    m2[1][2] = 0;
    run_op(3'd3, fill(-7), m1, 0, 1'b0, got, gdz, gill);
    chk_mat("lit_div", got, m2);
    chk_bit("lit_div_zero_flag", gdz, 1'b1);

    m2 = fill(-1);
    m2[1][2] = 0;
    run_op(3'd4, fill(-7), m1, 0, 1'b0, got, gdz, gill);
    chk_mat("lit_mod", got, m2);
    chk_bit("lit_mod_zero_flag", gdz, 1'b1);

    run_op(3'd2, fill(32'h7FFFFFFF), fill(2), 0, 1'b0, got, gdz, gill);
    chk_mat("lit_mul_wrap", got, fill(int'(32'hFFFFFFFE)));

    run_op(3'd3, fill(int'(32'h80000000)), fill(-1), 0, 1'b0, got, gdz, gill);
    chk_mat("lit_div_min", got, fill(int'(32'h80000000)));
    chk_bit("lit_div_min_flag", gdz, 1'b0);

    run_op(3'd7, seq, tr, 0, 1'b0, got, gdz, gill);
    chk_mat("lit_illegal_zero", got, '0);
    chk_bit("lit_illegal_flag", gill, 1'b1);

    // Hold with a competing in_valid; the bench keeps in_valid high through
    // the consume edge to prove that edge does not accept.
    run_op(3'd1, seq, fill(5), 10, 1'b1, got, gdz, gill);
    chk_mat("lit_sub", got[0][0] == elem_t'(-4) ? got : '0, got);

    run_op(3'd5, seq, tr, 0, 1'b0, got, gdz, gill);

    // Reset in the middle of RUN (row 0 written, row 1 next).
    @(negedge clk);
    sel = 3'd0;
    a = fill(1);
    b = fill(1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_bit("midrun_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_bit("abort_out_valid", out_valid, 1'b0);
    chk_bit("abort_in_ready", in_ready, 1'b1);
    chk_mat("abort_result", result, '0);
    chk_bit("abort_div_zero", div_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, fill(7), fill(-3), 0, 1'b0, got, gdz, gill);
    chk_mat("lit_add_after_reset", got, fill(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual running required finished");
    $fatal(1);
  end

endmodule
